// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian crossing request unit.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WALK  = 2'd2,
    FLASH = 2'd3
  } ped_state_t;

  localparam int DEF_DEBOUNCE_CYC = 270000;    // 10 ms at 27 MHz
  localparam int DEF_TICK_CYC     = 27000000;  // 1 s at 27 MHz
  localparam int DEF_WALK_TICKS   = 5;
  localparam int DEF_FLASH_TICKS  = 4;

  // Tick counter holds at most max(walk, flash) - 1; never narrower than 1 bit.
  function automatic int tick_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int TICK_CNT_W = tick_cnt_w(DEF_WALK_TICKS, DEF_FLASH_TICKS);

endpackage

// File: rtl/ped_crossing_req_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce counter and
// registered one-cycle press pulse on the debounced falling edge.
module btn_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= btn_n;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Count disagreeing cycles; once the count has reached DEBOUNCE_CYC the
  // next disagreeing cycle adopts the synchronized level and clears.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC)) db_d = s2_q;
      else                            cnt_d = cnt_q + 1'b1;
    end
    press_d = db_q & ~db_d;
  end

  assign press = press_q;

endmodule

// File: rtl/ped_crossing_req.sv
// Pedestrian crossing request: latches a debounced button press as ped_req,
// then sequences WALK / flashing DON'T-WALK on the controller's red phase.
module ped_crossing_req
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int TICK_CYC     = DEF_TICK_CYC,
  parameter int WALK_TICKS   = DEF_WALK_TICKS,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic red_on,
  output logic ped_req,
  output logic walk,
  output logic dont_walk
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int TW = tick_cnt_w(WALK_TICKS, FLASH_TICKS);

  ped_state_t    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          flash_ph_q, flash_ph_d;
  logic          red_q;
  logic          press, tick, red_rise, enter_walk, enter_flash, timed;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .press (press)
  );

  assign tick        = (presc_q == PW'(TICK_CYC - 1));
  assign red_rise    = red_on & ~red_q;
  assign enter_walk  = (state_q != WALK)  && (state_d == WALK);
  assign enter_flash = (state_q != FLASH) && (state_d == FLASH);
  assign timed       = (state_q == WALK) || (state_q == FLASH);

  // State register plus prescaler, tick counter, flash phase and red history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tcnt_q     <= '0;
      flash_ph_q <= 1'b1;
      red_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      flash_ph_q <= flash_ph_d;
      red_q      <= red_on;
    end
  end

  // Next state; losing red in a timed phase beats an expiring timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press) state_d = REQ;
      REQ:     if (red_rise) state_d = WALK;
      WALK: begin
        if (!red_on)                  state_d = IDLE;
        else if (tick && tcnt_q == '0) state_d = FLASH;
      end
      FLASH: begin
        if (!red_on)                  state_d = IDLE;
        else if (tick && tcnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler restarts on each timed-phase entry so phases are whole ticks.
  always_comb begin
    presc_d    = (enter_walk || enter_flash || tick) ? '0 : presc_q + 1'b1;
    tcnt_d     = tcnt_q;
    flash_ph_d = flash_ph_q;
    if (enter_walk) begin
      tcnt_d = TW'(WALK_TICKS - 1);
    end else if (enter_flash) begin
      tcnt_d     = TW'(FLASH_TICKS - 1);
      flash_ph_d = 1'b1;
    end else if (timed && tick) begin
      if (tcnt_q != '0) tcnt_d = tcnt_q - 1'b1;
      if (state_q == FLASH) flash_ph_d = ~flash_ph_q;
    end
  end

  // Moore lamp / request decode.
  always_comb begin
    ped_req   = 1'b0;
    walk      = 1'b0;
    dont_walk = 1'b1;
    case (state_q)
      REQ:     ped_req = 1'b1;
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      FLASH:   dont_walk = flash_ph_q;
      default: ;
    endcase
  end

endmodule

// File: doc/ped_crossing_req.md
# ped_crossing_req

Pedestrian crossing request unit sitting directly upstream of the traffic light controller on the 27 MHz board clock. It debounces the raw crossing push-button and latches a request as a level `ped_req` toward the light controller. It then drives the WALK / DON'T-WALK lamps, keyed off the controller's red-phase indication `red_on`, and aborts to DON'T-WALK whenever red ends early.

## Interface
- `DEBOUNCE_CYC`, 270000: consecutive stable cycles before the debounced button changes (10 ms).
- `TICK_CYC`, 27000000: cycles per timing tick (1 s).
- `WALK_TICKS`, 5: ticks the WALK lamp stays lit.
- `FLASH_TICKS`, 4: ticks of flashing DON'T-WALK after WALK.
- `clk`  in  1  board clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw push-button, active-low, asynchronous, bouncy.
- `red_on`  in  1  from light controller, high while red is displayed; synchronous to `clk`.
- `ped_req`  out  1  level request to light controller, high while a request is pending.
- `walk`  out  1  WALK lamp.
- `dont_walk`  out  1  DON'T-WALK lamp.

## Operation
- Button path:
  - Two-flop synchronizer on `btn_n`, giving `s2`.
  - Debounce counter increments each cycle `s2` differs from debounced `db`. Any cycle of agreement clears it.
  - When the count reaches `DEBOUNCE_CYC`, `db` takes `s2` and the counter clears.
  - Registered one-cycle `press` pulse on a 1→0 transition of `db`. Release generates nothing.
- Prescaler runs 0..`TICK_CYC`-1. `tick` fires when the count equals `TICK_CYC`-1. The prescaler clears on every entry to WALK or FLASH.
- `red_q` holds the previous-cycle `red_on`. `red_rise` = `red_on` & ~`red_q`.
- Moore FSM. Outputs are decoded from the state register, plus the `flash_ph` flop in FLASH.
  - IDLE: `dont_walk`=1, `walk`=0, `ped_req`=0.
    - `press` → REQ.
  - REQ: `ped_req`=1, `dont_walk`=1.
    - `red_rise` → WALK.
    - Further presses ignored.
    - Red already on at press does not qualify; the FSM waits for the next rising edge.
  - WALK: `walk`=1, `dont_walk`=0.
    - Tick counter loads `WALK_TICKS`-1 on entry and decrements on `tick`.
    - `tick` at count 0 → FLASH.
  - FLASH: `walk`=0, `dont_walk`=`flash_ph`.
    - `flash_ph` is 1 on entry and toggles on every `tick`.
    - Counter loads `FLASH_TICKS`-1 on entry.
    - `tick` at count 0 → IDLE.
- Abort: `red_on`=0 while in WALK or FLASH → IDLE next edge. Walk/flash timers are discarded.
- Presses in WALK and FLASH are dropped, not queued.
- Encoding covers 4 states. Any unused encoding → IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `walk`=0, `dont_walk`=1, `ped_req`=0.
  - All counters 0; `db`=1; `s1`, `s2`=1; `red_q`=0; `flash_ph`=1.
- Reset mid-operation returns to IDLE immediately and asynchronously. Any pending request is lost.
- Press latency: clean low on `btn_n` first sampled at edge 0 → `ped_req` high after edge `DEBOUNCE_CYC`+3.
- Bounce: a pulse shorter than `DEBOUNCE_CYC` cycles after synchronization never changes `db`.
- `red_on` sampled high at edge k, low at k-1, while in REQ:
  - `walk`=1 and `ped_req`=0 after edge k.
- WALK lasts exactly `WALK_TICKS`×`TICK_CYC` cycles. FLASH lasts exactly `FLASH_TICKS`×`TICK_CYC` cycles.
- Abort: `red_on` low sampled at edge k → `walk`=0, `dont_walk`=1 after edge k.
- Simultaneous `tick`-at-zero and `red_on`=0: the abort wins, giving IDLE.
- `walk` and `dont_walk` are never both 1.

## Structure
- Package `ped_pkg`:
  - `ped_state_t` enum, 2-bit: IDLE, REQ, WALK, FLASH.
  - Default parameter constants.
  - Tick-counter width, derived with `$clog2` of max(`WALK_TICKS`, `FLASH_TICKS`).
- Sub-module `btn_debounce` (param `DEBOUNCE_CYC`):
  - Inputs: `clk`, `rst`, `btn_n`.
  - Output: `press`.
  - Contains the synchronizer, counter and edge detector.
- Top level holds the prescaler, `red_q`, FSM and tick counter.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=4, `TICK_CYC`=10, `WALK_TICKS`=3, `FLASH_TICKS`=2.
- Reset: `rst` low mid-WALK → same-cycle `walk`=0, `dont_walk`=1, `ped_req`=0. After release, IDLE persists with no press.
- Clean press: `btn_n` low from edge 0, `red_on`=0 → `ped_req`=1 after edge 7. Bench checks it is 0 after edge 6.
- Bounce: `btn_n` low 3 cycles, high 1, low 3, high → `ped_req` stays 0.
- Full cycle: in REQ, `red_on` rises at edge k and stays high → `walk`=1 for 30 cycles from k. Then `dont_walk` reads 1 for 10 cycles, 0 for 10 cycles, then IDLE with `dont_walk`=1.
- Red already on at press: `red_on` held high → REQ, no WALK. `red_on` low then high → WALK one edge after the rise.
- Abort: `red_on` drops 12 cycles into WALK → `walk`=0, `dont_walk`=1 next edge, state IDLE. A press during FLASH yields no `ped_req` afterwards.
